// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO top level and its RAM pointer/flag
// controller: default address width, default flag thresholds and a helper
// that turns an address width into a word depth.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 32'd12;
    localparam int unsigned DEFAULT_AEMPTY_THRESH = 32'd4;
    // almost_full sits this many words below a completely full FIFO by default
    localparam int unsigned AFULL_MARGIN          = 32'd4;

    // Number of words addressable with an address of the given width.
    function automatic int unsigned fifo_depth(input int unsigned aw);
        fifo_depth = 32'd1 << aw;
    endfunction

    localparam int unsigned DEFAULT_AFULL_THRESH =
        fifo_depth(DEFAULT_ADDRESS_WIDTH) - AFULL_MARGIN;

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ram_ctrl_if
// Bundle between the FIFO front end (master: issues push/pop, observes
// status) and the pointer/flag controller (slave), including the RAM-side
// address and write-enable signals driven by the controller.
//   wr, rd                    push / pop requests            (master -> slave)
//   full, empty               occupancy extremes             (slave -> master)
//   almost_full, almost_empty threshold flags                (slave -> master)
//   count                     occupancy, ADDRESS_WIDTH+1 bits
//   ram_write_en              RAM write strobe
//   ram_write_address         RAM write port address
//   ram_read_address          RAM read port address (look-ahead)
//   overflow, underflow       sticky error flags, only with
//                             FIFO_RAM_CTRL_ERR_FLAGS_EN defined
// -----------------------------------------------------------------------------
interface fifo_ram_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) ();

    logic                     wr;
    logic                     rd;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [ADDRESS_WIDTH:0]   count;
    logic                     ram_write_en;
    logic [ADDRESS_WIDTH-1:0] ram_write_address;
    logic [ADDRESS_WIDTH-1:0] ram_read_address;
`ifdef FIFO_RAM_CTRL_ERR_FLAGS_EN
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr, rd,
        input  full, empty, almost_full, almost_empty, count,
        input  ram_write_en, ram_write_address, ram_read_address,
        input  overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output full, empty, almost_full, almost_empty, count,
        output ram_write_en, ram_write_address, ram_read_address,
        output overflow, underflow
    );
`else
    modport master (
        output wr, rd,
        input  full, empty, almost_full, almost_empty, count,
        input  ram_write_en, ram_write_address, ram_read_address
    );

    modport slave (
        input  wr, rd,
        output full, empty, almost_full, almost_empty, count,
        output ram_write_en, ram_write_address, ram_read_address
    );
`endif

endinterface

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrapping pointer register with an increment enable. The pointer rolls
// over naturally at 2**WIDTH. ptr_next is the value the register will take
// at the next rising edge, used as a look-ahead address for a RAM that
// registers its read address.
//   clk       clock
//   reset     asynchronous active-high reset (pointer -> 0)
//   inc       advance the pointer by one at the next edge
//   ptr       current (registered) pointer
//   ptr_next  combinational look-ahead: inc ? ptr+1 : ptr
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] ptr_next
);

    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ptr_r;
    logic [WIDTH-1:0] ptr_next_s;

    // look-ahead value; wrap comes for free from the fixed width
    always_comb begin
        ptr_next_s = ptr_r;
        if (inc) begin
            ptr_next_s = ptr_r + ONE_C;
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {WIDTH{1'b0}};
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign ptr      = ptr_r;
    assign ptr_next = ptr_next_s;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ram_ctrl
// Pointer and flag controller for a first-word-fall-through FIFO built on a
// synchronous dual-port block RAM. Accepts push/pop requests, drives the
// RAM write enable and both addresses, and keeps occupancy and flags.
// The read address is the look-ahead read pointer, so the RAM's registered
// read output always shows the head word. The RAM must forward write data
// on a same-address read/write (write-first) so a push into an empty FIFO
// appears at the head on the following cycle.
// Ports:
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-high reset
//   bus    fifo_ram_ctrl_if.slave (wr, rd in; flags, count, RAM controls out)
// Optional feature: define FIFO_RAM_CTRL_ERR_FLAGS_EN to add sticky
// overflow/underflow flags for rejected push/pop requests.
// -----------------------------------------------------------------------------
module fifo_ram_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned AFULL_THRESH  = fifo_depth(ADDRESS_WIDTH) - AFULL_MARGIN,
    parameter int unsigned AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic           clk,
    input  logic           reset,
    fifo_ram_ctrl_if.slave bus
);

    localparam int unsigned   CW       = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C  = CW'(fifo_depth(ADDRESS_WIDTH));
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic                     wr_accept_s;
    logic                     rd_accept_s;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_s;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_next_unused_s;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_s;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_next_s;
    logic [CW-1:0]            count_r;
    logic [CW-1:0]            count_next_s;
    logic                     full_r;
    logic                     empty_r;
    logic                     afull_r;
    logic                     aempty_r;

    // Request acceptance. A pop needs data; a push needs room unless a pop
    // frees a slot in the same cycle. Reset masks both so the RAM sees no
    // write and the read address stays at zero while reset is held.
    always_comb begin
        rd_accept_s = 1'b0;
        wr_accept_s = 1'b0;
        if (reset) begin
            rd_accept_s = 1'b0;
            wr_accept_s = 1'b0;
        end else begin
            rd_accept_s = bus.rd & ~empty_r;
            wr_accept_s = bus.wr & (~full_r | rd_accept_s);
        end
    end

    fifo_ptr #(
        .WIDTH    (ADDRESS_WIDTH)
    ) u_wr_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (wr_accept_s),
        .ptr      (wr_ptr_s),
        .ptr_next (wr_ptr_next_unused_s)
    );

    fifo_ptr #(
        .WIDTH    (ADDRESS_WIDTH)
    ) u_rd_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (rd_accept_s),
        .ptr      (rd_ptr_s),
        .ptr_next (rd_ptr_next_s)
    );

    // next occupancy; a simultaneous accepted push and pop cancel out
    always_comb begin
        count_next_s = count_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // occupancy and flags, all registered from the next count so that no
    // path exists from wr/rd to any status output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= ZERO_C;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= (AFULL_C == ZERO_C);
            aempty_r <= 1'b1;
        end else begin
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_C);
            empty_r  <= (count_next_s == ZERO_C);
            afull_r  <= (count_next_s >= AFULL_C);
            aempty_r <= (count_next_s <= AEMPTY_C);
        end
    end

`ifdef FIFO_RAM_CTRL_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // sticky capture of dropped push / pop requests, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (bus.wr & ~wr_accept_s);
            underflow_r <= underflow_r | (bus.rd & ~rd_accept_s);
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`endif

    assign bus.count             = count_r;
    assign bus.full              = full_r;
    assign bus.empty             = empty_r;
    assign bus.almost_full       = afull_r;
    assign bus.almost_empty      = aempty_r;
    assign bus.ram_write_en      = wr_accept_s;
    assign bus.ram_write_address = wr_ptr_s;
    assign bus.ram_read_address  = rd_ptr_next_s;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ram_ctrl
// Bench for fifo_ram_ctrl at ADDRESS_WIDTH = 3 (depth 8, both thresholds 4).
// A write-first dual-port RAM model sits on the controller's RAM ports; a
// reference model tracks pointers, count and error flags, and a scoreboard
// queue holds the words expected at the FIFO head.
// -----------------------------------------------------------------------------
module tb_fifo_ram_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFT   = 4;
    localparam int AET   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wdata;
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] head;

    int         n_checks = 0;
    int         n_fail   = 0;

    int         m_count;
    int         m_wptr;
    int         m_rptr;
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    fifo_ram_ctrl_if #(.ADDRESS_WIDTH(AW)) bus ();

    fifo_ram_ctrl #(
        .ADDRESS_WIDTH (AW),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // write-first synchronous dual-port RAM
    always @(posedge clk) begin
        if (bus.ram_write_en) mem[bus.ram_write_address] <= wdata;
        if (bus.ram_write_en && (bus.ram_write_address == bus.ram_read_address))
            head <= wdata;
        else
            head <= mem[bus.ram_read_address];
    end

    task automatic model_reset();
        m_count = 0;
        m_wptr  = 0;
        m_rptr  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        sb.delete();
    endtask

    // One clock of stimulus. Checks the combinational RAM controls before the
    // edge, updates the model/scoreboard on the edge, then compares the head.
    task automatic drive_cycle(input logic w, input logic r, input logic [7:0] d);
        logic       wacc;
        logic       racc;
        int         exp_ra;
        logic [7:0] popped;
        bus.wr = w;
        bus.rd = r;
        wdata  = d;
        racc   = r && (m_count != 0);
        wacc   = w && ((m_count != DEPTH) || racc);
        exp_ra = racc ? ((m_rptr + 1) % DEPTH) : m_rptr;
        #1;
        n_checks++;
        if (bus.ram_write_en !== wacc) begin
            n_fail++;
            $display("FAIL ram_write_en: got %b expected %b", bus.ram_write_en, wacc);
        end
        n_checks++;
        if (bus.ram_read_address !== 3'(exp_ra)) begin
            n_fail++;
            $display("FAIL ram_read_address: got %0d expected %0d", bus.ram_read_address, exp_ra);
        end
        n_checks++;
        if (bus.ram_write_address !== 3'(m_wptr)) begin
            n_fail++;
            $display("FAIL ram_write_address: got %0d expected %0d", bus.ram_write_address, m_wptr);
        end
        @(posedge clk);
        #1;
        if (racc) begin
            popped  = sb.pop_front();
            m_rptr  = (m_rptr + 1) % DEPTH;
            m_count = m_count - 1;
        end
        if (wacc) begin
            sb.push_back(d);
            m_wptr  = (m_wptr + 1) % DEPTH;
            m_count = m_count + 1;
        end
        if (w && !wacc) m_ovf = 1'b1;
        if (r && !racc) m_unf = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        if (m_count != 0) begin
            n_checks++;
            if (head !== sb[0]) begin
                n_fail++;
                $display("FAIL head: got %h expected %h", head, sb[0]);
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        wdata  = 8'h00;
        model_reset();
        #12;
        n_checks++;
        if (bus.ram_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wen: got %b expected 0", bus.ram_write_en);
        end
        n_checks++;
        if (bus.ram_read_address !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_raddr: got %0d expected 0", bus.ram_read_address);
        end
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_flags: got e/f/ae/af %b%b%b%b expected 1010",
                     bus.empty, bus.full, bus.almost_empty, bus.almost_full);
        end
        n_checks++;
        if (bus.count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        n_checks++;
        if (bus.ram_read_address !== 3'd0 || bus.ram_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ram: got raddr %0d wen %b expected 0 0",
                     bus.ram_read_address, bus.ram_write_en);
        end
`ifdef FIFO_RAM_CTRL_ERR_FLAGS_EN
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got ovf %b unf %b expected 0 0", bus.overflow, bus.underflow);
        end
`endif
    endtask

    // status outputs against the model after each push
    task automatic test_fill();
        logic [7:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(8'h11 * (i + 1));
            drive_cycle(1'b1, 1'b0, d);
            n_checks++;
            if (bus.count !== 4'(m_count) || bus.almost_full !== (m_count >= AFT) ||
                bus.full !== (m_count == DEPTH) || bus.empty !== 1'b0 ||
                bus.almost_empty !== (m_count <= AET)) begin
                n_fail++;
                $display("FAIL fill_status[%0d]: got cnt %0d f %b af %b ae %b e %b expected cnt %0d",
                         i, bus.count, bus.full, bus.almost_full, bus.almost_empty, bus.empty, m_count);
            end
        end
        drive_cycle(1'b1, 1'b0, 8'h99);
        n_checks++;
        if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL overfill: got cnt %0d full %b expected 8 1", bus.count, bus.full);
        end
`ifdef FIFO_RAM_CTRL_ERR_FLAGS_EN
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow: got ovf %b unf %b expected 1 0", bus.overflow, bus.underflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (bus.count !== 4'(m_count) || bus.almost_empty !== (m_count <= AET) ||
                bus.almost_full !== (m_count >= AFT) || bus.full !== 1'b0 ||
                bus.empty !== (m_count == 0)) begin
                n_fail++;
                $display("FAIL drain_status[%0d]: got cnt %0d expected %0d", i, bus.count, m_count);
            end
        end
        drive_cycle(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underpop: got cnt %0d empty %b expected 0 1", bus.count, bus.empty);
        end
`ifdef FIFO_RAM_CTRL_ERR_FLAGS_EN
        n_checks++;
        if (bus.underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: got %b expected 1", bus.underflow);
        end
`endif
    endtask

    task automatic test_full_rw();
        int w0;
        int r0;
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 8'(8'hA0 + i));
        w0 = m_wptr;
        r0 = m_rptr;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, 8'(8'hC0 + i));
            n_checks++;
            if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
                n_fail++;
                $display("FAIL full_rw[%0d]: got cnt %0d full %b expected 8 1", i, bus.count, bus.full);
            end
        end
        #1;
        n_checks++;
        if (bus.ram_write_address !== 3'((w0 + 3) % DEPTH) ||
            bus.ram_read_address !== 3'((r0 + 3) % DEPTH)) begin
            n_fail++;
            $display("FAIL full_rw_ptrs: got w %0d r %0d expected %0d %0d",
                     bus.ram_write_address, bus.ram_read_address, (w0 + 3) % DEPTH, (r0 + 3) % DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'h00);
        drive_cycle(1'b1, 1'b1, 8'h5A);
        n_checks++;
        if (bus.count !== 4'd1 || bus.empty !== 1'b0 || head !== 8'h5A) begin
            n_fail++;
            $display("FAIL empty_rw: got cnt %0d empty %b head %h expected 1 0 5a",
                     bus.count, bus.empty, head);
        end
    endtask

    task automatic test_wrap();
        int start_w;
        drive_cycle(1'b0, 1'b1, 8'h00);
        start_w = m_wptr;
        drive_cycle(1'b1, 1'b0, 8'h30);
        for (int i = 1; i < 20; i++) begin
            drive_cycle(1'b1, 1'b1, 8'(8'h30 + i));
            n_checks++;
            if (bus.count !== 4'd1) begin
                n_fail++;
                $display("FAIL wrap_count[%0d]: got %0d expected 1", i, bus.count);
            end
        end
        drive_cycle(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (bus.empty !== 1'b1 || bus.ram_write_address !== 3'((start_w + 20) % DEPTH)) begin
            n_fail++;
            $display("FAIL wrap_end: got empty %b waddr %0d expected 1 %0d",
                     bus.empty, bus.ram_write_address, (start_w + 20) % DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 8'(8'hE0 + i));
        n_checks++;
        if (bus.count !== 4'd5) begin
            n_fail++;
            $display("FAIL mid_pre_count: got %0d expected 5", bus.count);
        end
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.count !== 4'd0 || {bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got cnt %0d e/f/ae/af %b%b%b%b expected 0 1010",
                     bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full);
        end
        n_checks++;
        if (bus.ram_write_en !== 1'b0 || bus.ram_read_address !== 3'd0 ||
            bus.ram_write_address !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_ram: got wen %b raddr %0d waddr %0d expected 0 0 0",
                     bus.ram_write_en, bus.ram_read_address, bus.ram_write_address);
        end
`ifdef FIFO_RAM_CTRL_ERR_FLAGS_EN
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_err: got ovf %b unf %b expected 0 0", bus.overflow, bus.underflow);
        end
`endif
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        drive_cycle(1'b1, 1'b0, 8'h77);
        n_checks++;
        if (bus.count !== 4'd1 || head !== 8'h77) begin
            n_fail++;
            $display("FAIL post_reset_push: got cnt %0d head %h expected 1 77", bus.count, head);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
